// File: rtl/mem_port_arbiter.sv
// Arbitrates CPU and DMA requesters onto a single memory port (port 2).
// DMA can lock the port across transfers; a starvation counter bounds CPU priority.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // CPU requester
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sign,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  // DMA requester
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  // Memory port 2
  output logic        mem_rden2,
  output logic        mem_we2,
  output logic [31:0] mem_addr2,
  output logic [31:0] mem_din2,
  output logic [1:0]  mem_size,
  output logic        mem_sign,
  input  logic [31:0] mem_dout2
);

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  typedef enum logic [0:0] {StOpen, StDmaLocked} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            cpu_pend_q, dma_pend_q;

  // CPU keeps priority unless DMA has been starved; a lone requester always wins.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    case (state_q)
      StOpen: begin
        if (cpu_req && ((starve_cnt_q < CntMax) || !dma_req)) cpu_gnt = 1'b1;
        else                                                  dma_gnt = dma_req;
      end
      StDmaLocked: dma_gnt = dma_req;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StOpen:      if (dma_gnt && dma_lock) state_d = StDmaLocked;
      StDmaLocked: if (!dma_req || !dma_lock) state_d = StOpen;
      default:     state_d = StOpen;
    endcase
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (dma_gnt) begin
      starve_cnt_d = '0;
    end else if (dma_req && (starve_cnt_q != CntMax)) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StOpen;
      starve_cnt_q <= '0;
      cpu_pend_q   <= 1'b0;
      dma_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      cpu_pend_q   <= cpu_gnt && !cpu_we;
      dma_pend_q   <= dma_gnt && !dma_we;
    end
  end

  always_comb begin
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    mem_addr2 = '0;
    mem_din2  = '0;
    mem_size  = '0;
    mem_sign  = 1'b0;
    if (cpu_gnt) begin
      mem_rden2 = !cpu_we;
      mem_we2   = cpu_we;
      mem_addr2 = cpu_addr;
      mem_din2  = cpu_wdata;
      mem_size  = cpu_size;
      mem_sign  = cpu_sign;
    end else if (dma_gnt) begin
      mem_rden2 = !dma_we;
      mem_we2   = dma_we;
      mem_addr2 = dma_addr;
      mem_din2  = dma_wdata;
      mem_size  = 2'b10;
      mem_sign  = 1'b0;
    end
  end

  assign cpu_rvalid = cpu_pend_q;
  assign dma_rvalid = dma_pend_q;
  assign cpu_rdata  = mem_dout2;
  assign dma_rdata  = mem_dout2;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Table-driven bench for mem_port_arbiter with a read-response scoreboard.
module tb_mem_port_arbiter;

  localparam logic [31:0] Key = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_sign, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]  cpu_size;
  logic        dma_req, dma_lock, dma_we, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        mem_rden2, mem_we2, mem_sign;
  logic [31:0] mem_addr2, mem_din2, mem_dout2;
  logic [1:0]  mem_size;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_rden2(mem_rden2), .mem_we2(mem_we2), .mem_addr2(mem_addr2), .mem_din2(mem_din2),
    .mem_size(mem_size), .mem_sign(mem_sign), .mem_dout2(mem_dout2)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears one cycle after the read strobe.
  always @(posedge clk) mem_dout2 <= mem_rden2 ? (mem_addr2 ^ Key) : 32'h0;

  typedef struct {
    string       name;
    logic        rst;
    logic        creq, cwe;
    logic [31:0] caddr, cwdata;
    logic [1:0]  csize;
    logic        csign;
    logic        dreq, dlock, dwe;
    logic [31:0] daddr, dwdata;
    logic        ecg, edg;
  } vec_t;

  typedef struct {
    int          due;
    logic        is_cpu;
    logic [31:0] data;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic r,
                              input logic creq, input logic cwe, input logic [31:0] caddr,
                              input logic [31:0] cwdata, input logic [1:0] csize,
                              input logic csign, input logic dreq, input logic dlock,
                              input logic dwe, input logic [31:0] daddr,
                              input logic [31:0] dwdata, input logic ecg, input logic edg);
    vec_t v;
    v.name = nm; v.rst = r;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
    v.csize = csize; v.csign = csign;
    v.dreq = dreq; v.dlock = dlock; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata;
    v.ecg = ecg; v.edg = edg;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    logic        exp_cv, exp_dv;
    logic [31:0] exp_data;
    logic [68:0] exp_mem, act_mem;
    rsp_t        r;
    rst = v.rst;
    cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwdata;
    cpu_size = v.csize; cpu_sign = v.csign;
    dma_req = v.dreq; dma_lock = v.dlock; dma_we = v.dwe; dma_addr = v.daddr;
    dma_wdata = v.dwdata;
    @(negedge clk);
    exp_cv = 1'b0; exp_dv = 1'b0; exp_data = 32'h0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      r = sb.pop_front();
      exp_cv = r.is_cpu; exp_dv = !r.is_cpu; exp_data = r.data;
    end
    chk({v.name, ".rvalid"}, 128'({cpu_rvalid, dma_rvalid}), 128'({exp_cv, exp_dv}));
    if (exp_cv) chk({v.name, ".cpu_rdata"}, 128'(cpu_rdata), 128'(exp_data));
    if (exp_dv) chk({v.name, ".dma_rdata"}, 128'(dma_rdata), 128'(exp_data));
    chk({v.name, ".gnt"}, 128'({cpu_gnt, dma_gnt}), 128'({v.ecg, v.edg}));
    exp_mem = '0;
    if (v.ecg) exp_mem = {!v.cwe, v.cwe, v.caddr, v.cwdata, v.csize, v.csign};
    else if (v.edg) exp_mem = {!v.dwe, v.dwe, v.daddr, v.dwdata, 2'b10, 1'b0};
    act_mem = {mem_rden2, mem_we2, mem_addr2, mem_din2, mem_size, mem_sign};
    chk({v.name, ".mem"}, 128'(act_mem), 128'(exp_mem));
    if (!v.rst && v.ecg && !v.cwe) sb.push_back('{cyc + 1, 1'b1, v.caddr ^ Key});
    if (!v.rst && v.edg && !v.dwe) sb.push_back('{cyc + 1, 1'b0, v.daddr ^ Key});
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    int ncpu;
    bit found;

    // name rst | creq cwe caddr cwdata csize csign | dreq dlock dwe daddr dwdata | ecg edg
    vecs.push_back(mk("idle0",    0, 0,0,32'h0,    32'h0,        2'b00,0, 0,0,0,32'h0,    32'h0,        0,0));
    vecs.push_back(mk("idle1",    0, 0,0,32'h0,    32'h0,        2'b00,0, 0,0,0,32'h0,    32'h0,        0,0));
    vecs.push_back(mk("cpu_rd",   0, 1,0,32'h100,  32'h0,        2'b10,0, 0,0,0,32'h0,    32'h0,        1,0));
    vecs.push_back(mk("cpu_rsp",  0, 0,0,32'h0,    32'h0,        2'b00,0, 0,0,0,32'h0,    32'h0,        0,0));
    vecs.push_back(mk("cpu_wr",   0, 1,1,32'h104,  32'h11223344, 2'b01,1, 0,0,0,32'h0,    32'h0,        1,0));
    vecs.push_back(mk("dma_lk",   0, 0,0,32'h0,    32'h0,        2'b00,0, 1,1,0,32'h2000, 32'h0,        0,1));
    vecs.push_back(mk("dma_wr",   0, 1,0,32'h200,  32'h0,        2'b01,1, 1,0,1,32'h3000, 32'hDEADBEEF, 0,1));
    vecs.push_back(mk("cpu_back", 0, 1,0,32'h200,  32'h0,        2'b01,1, 0,0,0,32'h0,    32'h0,        1,0));
    vecs.push_back(mk("idle2",    0, 0,0,32'h0,    32'h0,        2'b00,0, 0,0,0,32'h0,    32'h0,        0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk("starve_c", 0, 1,0,32'h300 + 4*i, 32'h0, 2'b10,0, 1,0,0,32'h4000, 32'h0, 1,0));
    vecs.push_back(mk("starve_d", 0, 1,0,32'h310,  32'h0,        2'b10,0, 1,0,0,32'h4000, 32'h0,        0,1));
    vecs.push_back(mk("regain",   0, 1,0,32'h310,  32'h0,        2'b10,0, 0,0,0,32'h0,    32'h0,        1,0));
    vecs.push_back(mk("lk_a",     0, 0,0,32'h0,    32'h0,        2'b00,0, 1,1,0,32'h5000, 32'h0,        0,1));
    vecs.push_back(mk("lk_b",     0, 1,0,32'h600,  32'h0,        2'b10,0, 1,1,0,32'h5004, 32'h0,        0,1));
    vecs.push_back(mk("lk_drop",  0, 1,0,32'h600,  32'h0,        2'b10,0, 0,0,0,32'h0,    32'h0,        0,0));
    vecs.push_back(mk("lk_open",  0, 1,0,32'h600,  32'h0,        2'b10,0, 0,0,0,32'h0,    32'h0,        1,0));
    vecs.push_back(mk("pre_rst0", 0, 1,0,32'h620,  32'h0,        2'b10,0, 1,0,0,32'h8000, 32'h0,        1,0));
    vecs.push_back(mk("pre_rst1", 0, 1,0,32'h624,  32'h0,        2'b10,0, 1,0,0,32'h8000, 32'h0,        1,0));
    vecs.push_back(mk("rst_rd",   1, 1,0,32'h700,  32'h0,        2'b10,0, 1,0,0,32'h8000, 32'h0,        1,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk("post_rst", 0, 1,0,32'h704 + 4*i, 32'h0, 2'b10,0, 1,0,0,32'h8000, 32'h0, 1,0));
    vecs.push_back(mk("post_dma", 0, 1,0,32'h714,  32'h0,        2'b10,0, 1,0,0,32'h8000, 32'h0,        0,1));
    vecs.push_back(mk("lk_c",     0, 0,0,32'h0,    32'h0,        2'b00,0, 1,1,0,32'h9000, 32'h0,        0,1));
    vecs.push_back(mk("lk_rst",   1, 0,0,32'h0,    32'h0,        2'b00,0, 1,1,0,32'h9004, 32'h0,        0,1));
    vecs.push_back(mk("rst_open", 0, 1,0,32'h900,  32'h0,        2'b10,0, 0,0,0,32'h0,    32'h0,        1,0));
    vecs.push_back(mk("idle3",    0, 0,0,32'h0,    32'h0,        2'b00,0, 0,0,0,32'h0,    32'h0,        0,0));
    vecs.push_back(mk("idle4",    0, 0,0,32'h0,    32'h0,        2'b00,0, 0,0,0,32'h0,    32'h0,        0,0));

    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_size = 0; cpu_sign = 0;
    dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Starvation bound measured with both sides writing continuously.
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'hA00; cpu_size = 2'b10;
    dma_req = 1; dma_we = 1; dma_lock = 0; dma_addr = 32'hB00; dma_wdata = 32'h5A5A5A5A;
    ncpu = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (dma_gnt) found = 1;
      else begin
        if (cpu_gnt) ncpu++;
        @(posedge clk); #1;
      end
    end
    chk("starve_wait", 128'(found), 128'(1));
    chk("starve_cpu_cycles", 128'(ncpu), 128'(4));
    @(posedge clk); #1;
    dma_req = 0;
    @(negedge clk);
    chk("starve_regain", 128'({cpu_gnt, dma_gnt}), 128'(2'b10));
    @(posedge clk); #1;
    cpu_req = 0;
    @(negedge clk);
    chk("final_idle", 128'({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid}), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: count of consecutive denied DMA request cycles that forces a DMA grant.
REQ-002 SHALL have these clock and reset ports: clk in 1 (single clock, all state on rising edge); rst in 1 (synchronous, active-high reset).
REQ-003 SHALL have these CPU ports: cpu_req in 1; cpu_we in 1; cpu_addr in 32 (byte address); cpu_wdata in 32; cpu_size in 2; cpu_sign in 1; cpu_gnt out 1; cpu_rvalid out 1; cpu_rdata out 32.
REQ-004 SHALL have these DMA ports: dma_req in 1; dma_lock in 1 (hold ownership after this transfer); dma_we in 1; dma_addr in 32; dma_wdata in 32; dma_gnt out 1; dma_rvalid out 1; dma_rdata out 32.
REQ-005 SHALL have these memory port-2 ports: mem_rden2 out 1; mem_we2 out 1; mem_addr2 out 32; mem_din2 out 32; mem_size out 2; mem_sign out 1; mem_dout2 in 32 (valid one cycle after mem_rden2).

Function
REQ-006 SHALL assert at most one of cpu_gnt/dma_gnt in any cycle; grants are combinational from requests and registered state.
REQ-007 SHALL perform each transfer in the single cycle its grant is high; a requester holds req and its fields stable until granted.
REQ-008 SHALL implement state machine OPEN / DMA_LOCKED; reset state OPEN.
REQ-009 In OPEN: cpu_req wins when starve_cnt < STARVE_LIMIT; dma_req wins when cpu_req=0 or starve_cnt == STARVE_LIMIT.
REQ-010 SHALL go OPEN -> DMA_LOCKED on a clock edge where dma_gnt=1 and dma_lock=1.
REQ-011 In DMA_LOCKED: cpu_gnt=0; dma_gnt=dma_req.
REQ-012 SHALL go DMA_LOCKED -> OPEN on an edge where dma_req=0, or where dma_gnt=1 and dma_lock=0.
REQ-013 SHALL keep starve_cnt (width to hold STARVE_LIMIT): +1 each cycle dma_req=1 and dma_gnt=0, saturating at STARVE_LIMIT; cleared on any cycle dma_gnt=1.
REQ-014 SHALL drive, while cpu_gnt=1: mem_rden2=~cpu_we; mem_we2=cpu_we; mem_addr2/din2/size/sign from cpu_addr/wdata/size/sign.
REQ-015 SHALL drive, while dma_gnt=1: mem_rden2=~dma_we; mem_we2=dma_we; mem_addr2/din2 from dma_addr/wdata; mem_size=2'b10 (word); mem_sign=0.
REQ-016 SHALL drive all mem_* outputs to 0 when no grant.
REQ-017 SHALL register read ownership: a granted read causes rvalid=1 for exactly one cycle, the next cycle, to the requester that issued it only.
REQ-018 SHALL drive cpu_rdata and dma_rdata from mem_dout2 continuously; data is meaningful only with the matching rvalid.
REQ-019 SHALL produce no response for writes; write completes in its grant cycle.
REQ-020 SHALL allow back-to-back grants every cycle; a new read may be granted in the cycle a previous read's rvalid is high.

Reset
REQ-021 While rst=1 at a clock edge, SHALL set state=OPEN, starve_cnt=0 and pending-read owner=none.
REQ-022 SHALL force cpu_rvalid=dma_rvalid=0 in the cycle after reset.
REQ-023 A read granted in the cycle rst is asserted SHALL produce no rvalid.
REQ-024 Grants and mem_* SHALL follow REQ-009/014-016 from the current (reset) state.

Verification
REQ-025 CPU read only, cpu_addr=0x100, cpu_size=2'b10 -> same cycle cpu_gnt=1, mem_rden2=1, mem_addr2=0x100; next cycle cpu_rvalid=1, cpu_rdata=mem_dout2.
REQ-026 cpu_req and dma_req held continuously, STARVE_LIMIT=4 -> cpu_gnt cycles 1-4; dma_gnt cycle 5 with starve_cnt reset to 0; CPU regains grant cycle 6.
REQ-027 DMA read 0x2000 with dma_lock=1, then write 0x3000 data 0xDEADBEEF with dma_lock=0, cpu_req held high -> cpu_gnt=0 through the write cycle; mem_we2=1, mem_size=2'b10; cpu_gnt=1 in the following cycle.
REQ-028 DMA locked, then dma_req drops for one cycle -> state returns OPEN and pending cpu_req granted that cycle.
REQ-029 CPU read granted, rst=1 on the next edge -> no cpu_rvalid, state OPEN, starve_cnt=0.
REQ-030 No requests -> both grants 0, all mem_* outputs 0, no rvalid.
